// File: rtl/riscv_pkg.sv
// Shared encodings, FSM states and ALU operations for the multi-cycle RISC-V core.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP_32  = 7'b0111011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_SH1ADD = 3'b010;
    localparam logic [2:0] F3_SH2ADD = 3'b100;
    localparam logic [2:0] F3_SH3ADD = 3'b110;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [2:0] F3_W      = 3'b010;
    localparam logic [2:0] F3_D      = 3'b011;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_SUB   = 7'b0100000;
    localparam logic [6:0] F7_SHADD = 7'b0010000;
    localparam logic [6:0] F7_ADDUW = 7'b0000100;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SH1ADD,
        ALU_SH2ADD,
        ALU_SH3ADD,
        ALU_ADDUW
    } alu_op_e;

endpackage

// File: rtl/riscv_alu_p.sv
// Combinational ALU: base integer ops plus the Zba shift-add family.
module riscv_alu_p
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] y_o
);

    always_comb begin
        y_o = a_i + b_i;
        case (op_i)
            ALU_ADD:    y_o = a_i + b_i;
            ALU_SUB:    y_o = a_i - b_i;
            ALU_AND:    y_o = a_i & b_i;
            ALU_OR:     y_o = a_i | b_i;
            ALU_XOR:    y_o = a_i ^ b_i;
            ALU_SH1ADD: y_o = (a_i << 1) + b_i;
            ALU_SH2ADD: y_o = (a_i << 2) + b_i;
            ALU_SH3ADD: y_o = (a_i << 3) + b_i;
            ALU_ADDUW:  y_o = XLEN'(a_i[31:0]) + b_i;
            default:    y_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/riscv_core_mc.sv
// Multi-cycle RV core: FETCH -> EXEC (-> MEM) per instruction, illegal encodings park in HALT.
// state   | meaning
// FETCH   | imem_req high, waiting for the instruction word
// EXEC    | decode, register read, ALU / branch resolution
// MEM     | dmem_req high, waiting for the data handshake
// HALT    | illegal instruction seen, frozen until rst
module riscv_core_mc
    import riscv_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter bit          ZBA_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic            halted
);

    localparam logic [XLEN-1:0] PC_RST = RESET_PC[XLEN-1:0];
    localparam logic [2:0]      F3_MEM = (XLEN == 64) ? F3_D : F3_W;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic [XLEN-1:0] mwdata_q, mwdata_d;
    logic            mwe_q, mwe_d;
    logic [XLEN-1:0] regs_q [32];

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
    logic [XLEN-1:0] pc_plus4, tgt_raw, tgt;
    logic            illegal, is_mem, is_store, is_branch, is_jal, taken;
    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_b, alu_y;
    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;

    assign opcode  = instr_q[6:0];
    assign rd      = instr_q[11:7];
    assign funct3  = instr_q[14:12];
    assign rs1     = instr_q[19:15];
    assign rs2     = instr_q[24:20];
    assign funct7  = instr_q[31:25];
    // x0 is never written, so a plain array read already returns zero for it
    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];

    assign imm_i = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
    assign imm_s = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                    instr_q[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                    instr_q[30:21], 1'b0};

    assign pc_plus4 = pc_q + XLEN'(4);
    assign tgt_raw  = pc_q + (is_jal ? imm_j : imm_b);
    assign tgt      = {tgt_raw[XLEN-1:2], 2'b00};
    assign taken    = is_jal || (is_branch && ((rs1_val == rs2_val) ^ (funct3 == F3_BNE)));

    always_comb begin
        alu_op    = ALU_ADD;
        alu_b     = rs2_val;
        illegal   = 1'b1;
        is_mem    = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                alu_b   = imm_i;
                illegal = (funct3 != F3_ADD);
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    illegal = 1'b0;
                    case (funct3)
                        F3_ADD:  alu_op = ALU_ADD;
                        F3_XOR:  alu_op = ALU_XOR;
                        F3_OR:   alu_op = ALU_OR;
                        F3_AND:  alu_op = ALU_AND;
                        default: illegal = 1'b1;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
                    alu_op  = ALU_SUB;
                    illegal = 1'b0;
                end else if (ZBA_EN && funct7 == F7_SHADD) begin
                    illegal = 1'b0;
                    case (funct3)
                        F3_SH1ADD: alu_op = ALU_SH1ADD;
                        F3_SH2ADD: alu_op = ALU_SH2ADD;
                        F3_SH3ADD: alu_op = ALU_SH3ADD;
                        default:   illegal = 1'b1;
                    endcase
                end
            end
            OPC_OP_32: begin
                if (ZBA_EN && XLEN == 64 && funct7 == F7_ADDUW && funct3 == F3_ADD) begin
                    alu_op  = ALU_ADDUW;
                    illegal = 1'b0;
                end
            end
            OPC_LOAD: begin
                alu_b   = imm_i;
                is_mem  = 1'b1;
                illegal = (funct3 != F3_MEM);
            end
            OPC_STORE: begin
                alu_b    = imm_s;
                is_mem   = 1'b1;
                is_store = 1'b1;
                illegal  = (funct3 != F3_MEM);
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                illegal   = (funct3 != F3_BEQ) && (funct3 != F3_BNE);
            end
            OPC_JAL: begin
                is_jal  = 1'b1;
                illegal = 1'b0;
            end
            default: ;
        endcase
    end

    riscv_alu_p #(.XLEN(XLEN)) u_alu (
        .op_i (alu_op),
        .a_i  (rs1_val),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= PC_RST;
            instr_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mwe_q    <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mwe_q    <= mwe_d;
            if (rf_we && rd != 5'd0) regs_q[rd] <= rf_wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mwe_d    = mwe_q;
        rf_we    = 1'b0;
        rf_wdata = alu_y;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (illegal) begin
                    state_d = S_HALT;
                end else if (is_mem) begin
                    maddr_d  = alu_y;
                    mwdata_d = rs2_val;
                    mwe_d    = is_store;
                    state_d  = S_MEM;
                end else begin
                    pc_d     = taken ? tgt : pc_plus4;
                    rf_we    = !is_branch;
                    rf_wdata = is_jal ? pc_plus4 : alu_y;
                    state_d  = S_FETCH;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    rf_we    = !mwe_q;
                    rf_wdata = dmem_rdata;
                    pc_d     = pc_plus4;
                    state_d  = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    // Requests are masked by rst so an abandoned handshake drops in the reset cycle itself
    always_comb begin
        imem_req = !rst && (state_q == S_FETCH);
        dmem_req = !rst && (state_q == S_MEM);
        dmem_we  = dmem_req && mwe_q;
        retire   = !rst && (((state_q == S_EXEC) && !illegal && !is_mem) ||
                            ((state_q == S_MEM) && dmem_ready));
        halted   = (state_q == S_HALT);
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = maddr_q;
    assign dmem_wdata = mwdata_q;

endmodule

// File: tb/tb_riscv_core_mc.sv
// Directed bench for riscv_core_mc: small hand-assembled programs with hand-computed results.
module tb_riscv_core_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_nxt = 1'b1;

    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
    logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] imem_rdata;

    logic        imem_req_nz, imem_ready_nz, dmem_req_nz, dmem_we_nz, dmem_ready_nz;
    logic        retire_nz, halted_nz;
    logic [63:0] imem_addr_nz, dmem_addr_nz, dmem_wdata_nz, dmem_rdata_nz;
    logic [31:0] imem_rdata_nz;

    logic [31:0] prog [256];
    logic [63:0] exp_addr[$];
    logic [63:0] exp_data[$];
    logic [63:0] ftrace[$];
    logic [63:0] exp_trace[$];
    logic [63:0] ld_data;
    logic [3:0]  rhist;
    int          vecs = 0;
    int          errs = 0;
    int          retire_cnt, retire_nz_cnt, req_retires, stall_left, reqc;

    localparam logic [6:0] OP = 7'h33, OPI = 7'h13, OP32 = 7'h3B, LD = 7'h03, ST = 7'h23;
    localparam logic [6:0] BR = 7'h63, JL = 7'h6F;

    always #5 clk = ~clk;

    riscv_core_mc #(.XLEN(64), .RESET_PC(64'h0), .ZBA_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .retire(retire), .halted(halted)
    );

    riscv_core_mc #(.XLEN(64), .RESET_PC(64'h0), .ZBA_EN(1'b0)) dut_nz (
        .clk(clk), .rst(rst),
        .imem_req(imem_req_nz), .imem_addr(imem_addr_nz), .imem_ready(imem_ready_nz),
        .imem_rdata(imem_rdata_nz),
        .dmem_req(dmem_req_nz), .dmem_we(dmem_we_nz), .dmem_addr(dmem_addr_nz),
        .dmem_wdata(dmem_wdata_nz), .dmem_ready(dmem_ready_nz), .dmem_rdata(dmem_rdata_nz),
        .retire(retire_nz), .halted(halted_nz)
    );

    function automatic logic [31:0] rtype(logic [6:0] f7, int rs2, int rs1, int f3, int rd,
                                          logic [6:0] op);
        return {f7, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] itype(int imm, int rs1, int f3, int rd, logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] sd(int rs2, int rs1, int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b011, v[4:0], ST};
    endfunction

    function automatic logic [31:0] br(int f3, int rs1, int rs2, int imm);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], BR};
    endfunction

    function automatic logic [31:0] jal(int rd, int imm);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), JL};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = jal(0, 0);
    endtask

    // One clock: apply rst, answer both memories, then sample and score.
    task automatic cyc();
        @(posedge clk);
        #1;
        rst = rst_nxt;
        #1;
        imem_rdata    = prog[imem_addr[9:2]];
        imem_rdata_nz = prog[imem_addr_nz[9:2]];
        dmem_ready    = dmem_req && (stall_left == 0);
        dmem_rdata    = ld_data;
        dmem_ready_nz = dmem_req_nz;
        dmem_rdata_nz = '0;
        #1;
        check("req_exclusive", {63'd0, imem_req && dmem_req}, 64'd0);
        if (retire) retire_cnt++;
        if (retire_nz) retire_nz_cnt++;
        if (imem_req && imem_ready) ftrace.push_back(imem_addr);
        if (dmem_req && retire) req_retires++;
        if (dmem_req && dmem_ready && dmem_we) begin
            vecs++;
            assert (exp_addr.size() != 0) else begin
                errs++;
                $error("FAIL unexpected_store: observed addr %h data %h expected none",
                       dmem_addr, dmem_wdata);
            end
            if (exp_addr.size() != 0) begin
                check("st_addr", dmem_addr, exp_addr.pop_front());
                check("st_data", dmem_wdata, exp_data.pop_front());
            end
        end
        if (dmem_req && !dmem_ready && stall_left > 0) stall_left--;
    endtask

    task automatic do_reset();
        rst_nxt = 1'b1;
        cyc();
        cyc();
        check("rst_imem_req", {63'd0, imem_req}, 64'd0);
        check("rst_imem_addr", imem_addr, 64'h0);
        check("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
        check("rst_dmem_we", {63'd0, dmem_we}, 64'd0);
        check("rst_dmem_addr", dmem_addr, 64'h0);
        check("rst_dmem_wdata", dmem_wdata, 64'h0);
        check("rst_retire", {63'd0, retire}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        retire_cnt = 0;
        retire_nz_cnt = 0;
        req_retires = 0;
        ftrace.delete();
        rst_nxt = 1'b0;
    endtask

    initial begin
        imem_ready = 1'b1;
        imem_ready_nz = 1'b1;
        dmem_ready = 1'b0;
        dmem_ready_nz = 1'b0;
        imem_rdata = '0;
        imem_rdata_nz = '0;
        dmem_rdata = '0;
        dmem_rdata_nz = '0;
        ld_data = '0;
        stall_left = 0;
        retire_cnt = 0;
        retire_nz_cnt = 0;
        req_retires = 0;

        // A: two dependent ADDIs, result observed through a store
        clear_prog();
        prog[0] = itype(5, 0, 0, 1, OPI);
        prog[1] = itype(-7, 1, 0, 2, OPI);
        prog[2] = sd(2, 0, 0);
        exp_addr.push_back(64'h0); exp_data.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (c == 0) begin
                check("first_fetch_req", {63'd0, imem_req}, 64'd1);
                check("first_fetch_addr", imem_addr, 64'h0);
            end
            rhist[c] = retire;
        end
        check("retire_cycles_1to4", {60'd0, rhist}, 64'hA);
        repeat (6) cyc();
        check("a_stores_done", 64'(exp_addr.size()), 64'd0);

        // B: ALU, Zba, ADD.UW, load, x0, then an illegal word
        clear_prog();
        prog[0]  = itype(3, 0, 0, 1, OPI);
        prog[1]  = itype(100, 0, 0, 2, OPI);
        prog[2]  = rtype(7'b0010000, 2, 1, 6, 3, OP);
        prog[3]  = sd(3, 0, 0);
        prog[4]  = itype(0, 0, 3, 4, LD);
        prog[5]  = itype(1, 0, 0, 5, OPI);
        prog[6]  = rtype(7'b0000100, 5, 4, 0, 6, OP32);
        prog[7]  = sd(6, 0, 16);
        prog[8]  = rtype(7'b0100000, 3, 5, 0, 7, OP);
        prog[9]  = rtype(7'b0000000, 1, 3, 4, 8, OP);
        prog[10] = rtype(7'b0000000, 2, 3, 7, 9, OP);
        prog[11] = rtype(7'b0000000, 2, 1, 6, 10, OP);
        prog[12] = sd(7, 0, 24);
        prog[13] = sd(8, 0, 32);
        prog[14] = sd(9, 0, 40);
        prog[15] = sd(10, 0, 48);
        prog[16] = itype(9, 0, 0, 0, OPI);
        prog[17] = sd(0, 0, 56);
        prog[18] = 32'hFFFF_FFFF;
        ld_data = 64'hFFFF_FFFF_0000_0010;
        exp_addr.push_back(64'd0);  exp_data.push_back(64'd124);
        exp_addr.push_back(64'd16); exp_data.push_back(64'd17);
        exp_addr.push_back(64'd24); exp_data.push_back(64'hFFFF_FFFF_FFFF_FF85);
        exp_addr.push_back(64'd32); exp_data.push_back(64'd127);
        exp_addr.push_back(64'd40); exp_data.push_back(64'd100);
        exp_addr.push_back(64'd48); exp_data.push_back(64'd103);
        exp_addr.push_back(64'd56); exp_data.push_back(64'd0);
        do_reset();
        repeat (60) cyc();
        check("b_stores_done", 64'(exp_addr.size()), 64'd0);
        check("b_retire_count", 64'(retire_cnt), 64'd18);
        check("b_halted", {63'd0, halted}, 64'd1);
        check("b_halt_no_fetch", {63'd0, imem_req}, 64'd0);
        check("nz_halted", {63'd0, halted_nz}, 64'd1);
        check("nz_no_fetch", {63'd0, imem_req_nz}, 64'd0);
        check("nz_retire_count", 64'(retire_nz_cnt), 64'd2);
        check("nz_x3_unchanged", dut_nz.regs_q[3], 64'd0);

        // C: branches and JAL, checked through the fetch address trace
        clear_prog();
        prog[0]  = itype(1, 1, 0, 1, OPI);
        prog[1]  = itype(2, 0, 0, 2, OPI);
        prog[2]  = br(0, 1, 2, 16);
        prog[3]  = jal(5, 52);
        prog[16] = br(0, 0, 0, -64);
        prog[6]  = br(1, 1, 0, 8);
        prog[8]  = sd(5, 0, 0);
        prog[9]  = sd(1, 0, 8);
        prog[10] = jal(0, 6);
        exp_addr.push_back(64'd0); exp_data.push_back(64'd16);
        exp_addr.push_back(64'd8); exp_data.push_back(64'd2);
        exp_trace = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h40, 64'h0, 64'h4, 64'h8,
                      64'h18, 64'h20, 64'h24, 64'h28, 64'h2C, 64'h2C};
        do_reset();
        repeat (40) cyc();
        check("c_trace_len_ok", {63'd0, ftrace.size() >= exp_trace.size()}, 64'd1);
        for (int i = 0; i < exp_trace.size() && i < ftrace.size(); i++)
            check($sformatf("c_fetch_%0d", i), ftrace[i], exp_trace[i]);
        check("c_stores_done", 64'(exp_addr.size()), 64'd0);

        // D: store with three wait cycles on dmem_ready
        clear_prog();
        prog[0] = itype(256, 0, 0, 1, OPI);
        prog[1] = itype(55, 0, 0, 2, OPI);
        prog[2] = sd(2, 1, 8);
        exp_addr.push_back(64'h108); exp_data.push_back(64'd55);
        do_reset();
        stall_left = 3;
        reqc = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (dmem_req) begin
                reqc++;
                check("d_addr_stable", dmem_addr, 64'h108);
                check("d_we", {63'd0, dmem_we}, 64'd1);
            end
        end
        check("d_req_cycles", 64'(reqc), 64'd4);
        check("d_single_retire", 64'(req_retires), 64'd1);
        check("d_stores_done", 64'(exp_addr.size()), 64'd0);

        // E: reset during a stalled load
        clear_prog();
        prog[0] = itype(0, 0, 3, 3, LD);
        do_reset();
        stall_left = 1000;
        repeat (3) cyc();
        check("e_load_pending", {63'd0, dmem_req}, 64'd1);
        check("e_load_we", {63'd0, dmem_we}, 64'd0);
        rst_nxt = 1'b1;
        cyc();
        check("e_rst_drops_req", {63'd0, dmem_req}, 64'd0);
        rst_nxt = 1'b0;
        cyc();
        check("e_no_reissue", {63'd0, dmem_req}, 64'd0);
        check("e_dmem_addr", dmem_addr, 64'h0);
        check("e_pc_reset", imem_addr, 64'h0);
        check("e_first_fetch", {63'd0, imem_req}, 64'd1);
        check("e_rd_clear", dut.regs_q[3], 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/riscv_core_mc.md
RISCV_CORE_MC -- requirements
Module: riscv_core_mc

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address, truncated to XLEN.
REQ-003 SHALL have parameter ZBA_EN, default 1, meaning Zba instructions are decoded; when 0 they are illegal.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 imem_req  out  1  fetch request, held until accepted.
REQ-007 imem_addr  out  XLEN  fetch byte address, stable while imem_req=1.
REQ-008 imem_ready  in  1  fetch accepted; imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 dmem_req  out  1  data request, held until accepted.
REQ-011 dmem_we  out  1  1 = store, 0 = load; stable while dmem_req=1.
REQ-012 dmem_addr  out  XLEN  data byte address.
REQ-013 dmem_wdata  out  XLEN  store data.
REQ-014 dmem_ready  in  1  data accepted; dmem_rdata is valid in the same cycle for loads.
REQ-015 dmem_rdata  in  XLEN  load data.
REQ-016 retire  out  1  one-cycle pulse per completed instruction.
REQ-017 halted  out  1  high from an illegal-instruction trap until reset.

Function
REQ-018 SHALL use the FSM states FETCH, EXEC, MEM and HALT.
- FETCH: imem_req=1; on imem_ready, latch the instruction and go to EXEC.
REQ-019 EXEC SHALL decode the instruction, read rs1/rs2 and compute the result.
- ALU/branch instructions: write rd, update pc, pulse retire, go to FETCH.
- Load/store: latch address and data, go to MEM.
- Illegal instructions: go to HALT with no register write.
REQ-020 MEM SHALL hold dmem_req=1 until dmem_ready.
- On that cycle, a load writes rd from dmem_rdata; retire pulses; pc advances by 4; next state is FETCH.
REQ-021 HALT SHALL be absorbing.
- halted=1, both requests 0, no state changes until rst.
REQ-022 Supported instructions SHALL be ADDI, ADD, SUB, AND, OR, XOR, BEQ, BNE and JAL.
- Load/store: LD/SD when XLEN=64, LW/SW when XLEN=32.
- When ZBA_EN=1: SH1ADD/SH2ADD/SH3ADD, plus ADD.UW when XLEN=64.
- Every other encoding is illegal.
REQ-023 Arithmetic SHALL be modulo 2^XLEN.
- Immediates are sign-extended to XLEN.
- SHnADD = (rs1<<n)+rs2.
- ADD.UW = zext(rs1[31:0])+rs2.
REQ-024 Branches and JAL SHALL set pc to pc+imm when taken; otherwise pc advances by 4.
- JAL writes pc+4 to rd.
- Bits [1:0] of the target are forced to 0.
REQ-025 x0 SHALL read as zero; writes to x0 are discarded.
REQ-026 Latency with zero-wait memories SHALL be 2 cycles per ALU/branch instruction and 3 cycles per load/store.
- Each cycle with ready=0 adds one cycle.
REQ-027 dmem_req and imem_req SHALL never be asserted in the same cycle.
REQ-028 pc wrap-around past 2^XLEN-4 SHALL be modulo, with no trap.

Reset
REQ-029 On rst, the following SHALL take their reset values on the next edge, overriding any in-flight handshake; the abandoned request is not reissued:
- state=FETCH, pc=RESET_PC, all 32 registers=0
- imem_req=0 during the reset cycle, imem_addr=RESET_PC
- dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0
- retire=0, halted=0
REQ-030 The first imem_req SHALL be asserted in the first cycle after rst deasserts.

Structure
REQ-031 A shared package riscv_pkg SHALL hold:
- opcode constants (OP, OP_IMM, OP_32, LOAD, STORE, BRANCH, JAL)
- funct3/funct7 constants, including Zba funct7 7'b0010000 and 7'b0000100
- the FSM state enum
- the ALU-operation enum
REQ-032 The ALU SHALL be a single combinational sub-module, riscv_alu_p, parametrised by XLEN.
- The register file and FSM stay in riscv_core_mc.

Verification
REQ-033 Zero-wait memories, program ADDI x1,x0,5 then ADDI x2,x1,-7 -> x2=64'hFFFF_FFFF_FFFF_FFFE; retire pulses at cycles 2 and 4 after reset release.
REQ-034 x1=3, x2=100, SH3ADD x3,x1,x2 -> x3=124; with ZBA_EN=0 the same word -> halted=1, x3 unchanged, no further imem_req.
REQ-035 XLEN=64, x1=64'hFFFF_FFFF_0000_0010, x2=1, ADD.UW x3,x1,x2 -> x3=17.
REQ-036 SD x2,8(x1) with x1=64'h100 and dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_addr=64'h108 stable throughout; single retire pulse.
REQ-037 BEQ taken from pc=64'h40, offset -64 -> next imem_addr=0; ADDI x0,x0,9 -> x0 reads 0.
REQ-038 Assert rst during a stalled load (dmem_ready=0) -> next cycle dmem_req=0, pc=RESET_PC, rd not written.
